// File: rtl/ysyx_24090012_mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx_24090012_mem_arb_pkg                                     |
// | Description : Shared types and constants for the IFU/LSU SRAM arbiter:    |
// |               arbiter state enum, master identifiers, default error data  |
// |               and the winner-selection helper.                            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package ysyx_24090012_mem_arb_pkg;

  // Arbiter ownership state: idle, or the SRAM port is owned by one master.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_IFU = 2'd1,
    ST_GNT_LSU = 2'd2
  } arb_state_e;

  // Master identifiers, also used as the round-robin "last served" pointer.
  localparam logic c_MST_IFU = 1'b0;
  localparam logic c_MST_LSU = 1'b1;

  // Read data returned to a master whose transaction timed out.
  localparam logic [31:0] c_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Watchdog counter width.
  localparam int c_WDOG_W = 8;

  // Choose the winning master among the valid requesters. prefer_ifu only
  // matters when both masters request in the same cycle.
  function automatic logic pick_master(input logic ifu_v,
                                       input logic lsu_v,
                                       input logic prefer_ifu);
    logic win;
    if (ifu_v && lsu_v) begin
      win = prefer_ifu ? c_MST_IFU : c_MST_LSU;
    end else if (ifu_v) begin
      win = c_MST_IFU;
    end else begin
      win = c_MST_LSU;
    end
    return win;
  endfunction

endpackage : ysyx_24090012_mem_arb_pkg
`default_nettype wire

// File: rtl/ysyx_24090012_arb_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx_24090012_arb_wdog                                        |
// | Description : Response watchdog. Counts granted cycles that saw no SRAM    |
// |               response; flags expiry once the count reaches TIMEOUT and   |
// |               then holds (no wrap) until cleared by the next grant.       |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module ysyx_24090012_arb_wdog
  import ysyx_24090012_mem_arb_pkg::*;
#(
  parameter logic [c_WDOG_W-1:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [c_WDOG_W-1:0] r_cnt;

  assign o_expired = (r_cnt == TIMEOUT);

  // Count unanswered granted cycles; saturate at expiry, restart on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : ysyx_24090012_arb_wdog
`default_nettype wire

// File: rtl/ysyx_24090012_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx_24090012_mem_arb                                         |
// | Description : Two-master (IFU read-only, LSU read/write) to one SRAM      |
// |               arbiter. Latches the granted request, drives the SRAM from  |
// |               that copy and routes the response only to the owner. A      |
// |               watchdog forces an error response if the SRAM hangs.        |
// |               Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie    |
// |               breaking; otherwise LSU has fixed priority over IFU.        |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module ysyx_24090012_mem_arb
  import ysyx_24090012_mem_arb_pkg::*;
#(
  parameter logic [c_WDOG_W-1:0] TIMEOUT   = 8'd255,
  parameter logic [31:0]         ERR_RDATA = c_ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  // IFU request / response
  input  logic        i_ifu_valid,
  input  logic [31:0] i_ifu_addr,
  output logic        o_ifu_ready,
  output logic [31:0] o_ifu_rdata,
  // LSU request / response
  input  logic        i_lsu_valid,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_wmask,
  input  logic        i_lsu_wen,
  output logic        o_lsu_ready,
  output logic [31:0] o_lsu_rdata,
  // SRAM request / response
  output logic        o_sram_valid,
  output logic [31:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  output logic [3:0]  o_sram_wmask,
  output logic        o_sram_wen,
  input  logic        i_sram_ready,
  input  logic [31:0] i_sram_rdata,
  // Watchdog expiry pulse
  output logic        o_err
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_wen;

  logic        w_any_req;
  logic        w_prefer_ifu;
  logic        w_win;
  logic        w_grant;
  logic        w_granted;
  logic        w_owner;
  logic        w_expired;
  logic        w_resp;
  logic        w_timeout;
  logic [31:0] w_rdata;

  assign w_any_req = i_ifu_valid | i_lsu_valid;
  assign w_win     = pick_master(i_ifu_valid, i_lsu_valid, w_prefer_ifu);
  assign w_grant   = (r_state == ST_IDLE) && w_any_req;
  assign w_granted = (r_state != ST_IDLE);
  assign w_owner   = (r_state == ST_GNT_LSU) ? c_MST_LSU : c_MST_IFU;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;

  // Remember which master was granted last; reset as LSU so IFU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_MST_LSU;
    end else if (w_grant) begin
      r_last <= w_win;
    end
  end

  assign w_prefer_ifu = (r_last == c_MST_LSU);
`else
  // Fixed priority: LSU always wins a tie.
  assign w_prefer_ifu = 1'b0;
`endif

  // Capture the winner's request at grant time; master-side changes are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_wen   <= 1'b0;
    end else if (w_grant) begin
      if (w_win == c_MST_LSU) begin
        r_addr  <= i_lsu_addr;
        r_wdata <= i_lsu_wdata;
        r_wmask <= i_lsu_wmask;
        r_wen   <= i_lsu_wen;
      end else begin
        r_addr  <= i_ifu_addr;
        r_wdata <= '0;
        r_wmask <= '0;
        r_wen   <= 1'b0;
      end
    end
  end

  // Watchdog is cleared on every grant and advances on unanswered granted cycles.
  ysyx_24090012_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_grant),
    .i_en      (w_granted && !i_sram_ready),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and completion decode; a real SRAM response beats a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = (w_win == c_MST_LSU) ? ST_GNT_LSU : ST_GNT_IFU;
        end
      end
      ST_GNT_IFU, ST_GNT_LSU: begin
        if (i_sram_ready) begin
          w_resp      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_resp      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Drive SRAM from the latched copy and route the response to the owner only.
  always_comb begin
    o_sram_valid = w_granted && !w_timeout;
    o_sram_addr  = o_sram_valid ? r_addr  : '0;
    o_sram_wdata = o_sram_valid ? r_wdata : '0;
    o_sram_wmask = o_sram_valid ? r_wmask : '0;
    o_sram_wen   = o_sram_valid ? r_wen   : 1'b0;

    w_rdata      = w_timeout ? ERR_RDATA : i_sram_rdata;

    o_ifu_ready  = w_resp && (w_owner == c_MST_IFU);
    o_ifu_rdata  = o_ifu_ready ? w_rdata : '0;
    o_lsu_ready  = w_resp && (w_owner == c_MST_LSU);
    o_lsu_rdata  = o_lsu_ready ? w_rdata : '0;

    o_err        = w_timeout;
  end

endmodule : ysyx_24090012_mem_arb
`default_nettype wire

// File: tb/tb_ysyx_24090012_mem_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_ysyx_24090012_mem_arb                                      |
// | Description : Randomized self-checking bench for the IFU/LSU SRAM arbiter |
// |               with a transaction-level reference model. Honours           |
// |               ARB_ROUND_ROBIN_EN when predicting tie winners.             |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_ysyx_24090012_mem_arb;

  localparam logic [7:0]  c_TIMEOUT = 8'd4;
  localparam logic [31:0] c_ERR     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_valid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_ready;
  logic [31:0] ifu_rdata;
  logic        lsu_valid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_wen = 1'b0;
  logic        lsu_ready;
  logic [31:0] lsu_rdata;
  logic        sram_valid;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic        sram_wen;
  logic        sram_ready = 1'b0;
  logic [31:0] sram_rdata = '0;
  logic        err;

  ysyx_24090012_mem_arb #(
    .TIMEOUT   (c_TIMEOUT),
    .ERR_RDATA (c_ERR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ifu_valid  (ifu_valid),
    .i_ifu_addr   (ifu_addr),
    .o_ifu_ready  (ifu_ready),
    .o_ifu_rdata  (ifu_rdata),
    .i_lsu_valid  (lsu_valid),
    .i_lsu_addr   (lsu_addr),
    .i_lsu_wdata  (lsu_wdata),
    .i_lsu_wmask  (lsu_wmask),
    .i_lsu_wen    (lsu_wen),
    .o_lsu_ready  (lsu_ready),
    .o_lsu_rdata  (lsu_rdata),
    .o_sram_valid (sram_valid),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .o_sram_wmask (sram_wmask),
    .o_sram_wen   (sram_wen),
    .i_sram_ready (sram_ready),
    .i_sram_rdata (sram_rdata),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: master 0 = IFU, 1 = LSU; own = -1 when the port is free.
  int          own     = -1;
  int          age     = 0;   // granted cycles already elapsed for the current owner
  int          lat     = 0;   // SRAM answers in granted cycle number lat (0 = never)
  int          last    = 1;   // last master granted; LSU after reset
  bit          dropped = 1'b0;
  bit          pend    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wmask [2];
  bit          p_wen   [2];
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wmask;
  bit          e_wen;
  int          n_tmo   = 0;
  int          n_tie   = 0;

  task automatic drive_masters();
    ifu_valid = pend[0];
    ifu_addr  = pend[0] ? p_addr[0] : $urandom;
    lsu_valid = pend[1];
    lsu_addr  = pend[1] ? p_addr[1]  : $urandom;
    lsu_wdata = pend[1] ? p_wdata[1] : $urandom;
    lsu_wmask = pend[1] ? p_wmask[1] : 4'($urandom);
    lsu_wen   = pend[1] ? p_wen[1]   : 1'($urandom);
    if (own >= 0) begin
      // Owner is free to change its inputs while granted; the arbiter must not care.
      if ($urandom_range(0, 3) == 0) begin
        if (own == 0) begin
          ifu_addr = $urandom;
        end else begin
          lsu_addr  = $urandom;
          lsu_wdata = $urandom;
          lsu_wmask = 4'($urandom);
          lsu_wen   = 1'($urandom);
        end
      end
      if (dropped) begin
        if (own == 0) ifu_valid = 1'b0;
        else          lsu_valid = 1'b0;
      end
    end
  endtask

  // One clock cycle of random stimulus, prediction and comparison.
  task automatic step(input bit gen);
    bit          done;
    bit          tmo;
    bit          rdy [2];
    logic [31:0] rd  [2];
    int          w;
    done = 1'b0; tmo = 1'b0;
    rdy[0] = 1'b0; rdy[1] = 1'b0; rd[0] = '0; rd[1] = '0;

    @(posedge clk); #1;
    if (gen) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m]    = 1'b1;
          p_addr[m]  = $urandom;
          p_wdata[m] = $urandom;
          p_wmask[m] = 4'($urandom);
          p_wen[m]   = 1'($urandom);
        end
      end
    end
    if (own >= 0 && !dropped && $urandom_range(0, 7) == 0) dropped = 1'b1;
    drive_masters();
    sram_rdata = $urandom;
    if (own >= 0) sram_ready = (lat != 0) && (age + 1 == lat);
    else          sram_ready = 1'($urandom);
    #1;

    if (own < 0) begin
      check("idle_sram_valid", sram_valid, 0);
    end else begin
      if (sram_ready) begin
        done = 1'b1;
      end else if (age == int'(c_TIMEOUT)) begin
        done = 1'b1;
        tmo  = 1'b1;
        n_tmo++;
      end
      check("gnt_sram_valid", sram_valid, !tmo);
      if (!tmo) begin
        check("gnt_sram_addr", sram_addr, e_addr);
        check("gnt_sram_wdata", sram_wdata, e_wdata);
        check("gnt_sram_wmask", sram_wmask, e_wmask);
        check("gnt_sram_wen", sram_wen, e_wen);
      end
      if (done) begin
        rdy[own] = 1'b1;
        rd[own]  = tmo ? c_ERR : sram_rdata;
      end
    end
    check("ifu_ready", ifu_ready, rdy[0]);
    check("ifu_rdata", ifu_rdata, rd[0]);
    check("lsu_ready", lsu_ready, rdy[1]);
    check("lsu_rdata", lsu_rdata, rd[1]);
    check("err", err, tmo);

    // Advance the model to the next cycle.
    if (own >= 0) begin
      if (done) begin
        pend[own] = 1'b0;
        own       = -1;
        dropped   = 1'b0;
      end else begin
        age++;
      end
    end else if (pend[0] || pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (pend[0] && pend[1]) w = (last == 1) ? 0 : 1;
      else                    w = pend[1] ? 1 : 0;
`else
      w = pend[1] ? 1 : 0;
`endif
      if (pend[0] && pend[1]) n_tie++;
      own     = w;
      last    = w;
      age     = 0;
      lat     = $urandom_range(0, 5);
      e_addr  = p_addr[w];
      e_wdata = (w == 1) ? p_wdata[1] : 32'h0;
      e_wmask = (w == 1) ? p_wmask[1] : 4'h0;
      e_wen   = (w == 1) ? p_wen[1]   : 1'b0;
    end
  endtask

  initial begin
    int guard;
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Reset state: everything low while reset is held and in the cycle after release.
    #3;
    check("rst_sram_valid", sram_valid, 0);
    check("rst_ifu_ready", ifu_ready, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_err", err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_sram_valid", sram_valid, 0);
    check("post_rst_sram_addr", sram_addr, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) step(1'b1);

    // Let outstanding requests finish.
    guard = 0;
    while ((own >= 0 || pend[0] || pend[1]) && guard < 200) begin
      step(1'b0);
      guard++;
    end
    check("drain_bounded", (guard < 200), 1);
    check("saw_timeouts", (n_tmo > 0), 1);
    check("saw_ties", (n_tie > 0), 1);

    // Reset pulled during an LSU grant: grant dropped at once, no ready pulse.
    @(posedge clk); #1;
    ifu_valid = 1'b0; sram_ready = 1'b0;
    lsu_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wdata = 32'h1234_5678;
    lsu_wmask = 4'hF; lsu_wen = 1'b1;
    #1;
    check("rm_idle_valid", sram_valid, 0);
    @(posedge clk); #1;
    check("rm_gnt_valid", sram_valid, 1);
    check("rm_gnt_addr", sram_addr, 32'h8000_0100);
    check("rm_gnt_wdata", sram_wdata, 32'h1234_5678);
    check("rm_gnt_wen", sram_wen, 1);
    rst_n = 1'b0;
    #1;
    check("rm_async_valid", sram_valid, 0);
    check("rm_async_addr", sram_addr, 0);
    check("rm_async_lsu_ready", lsu_ready, 0);
    lsu_valid = 1'b0; sram_ready = 1'b1;
    @(posedge clk); #1;
    check("rm_hold_valid", sram_valid, 0);
    check("rm_hold_lsu_ready", lsu_ready, 0);
    sram_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rm_release_valid", sram_valid, 0);

    // IFU alone after reset, SRAM answers one cycle after seeing valid.
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    check("ifu_t_valid", sram_valid, 0);
    @(posedge clk); #1;
    check("ifu_t1_valid", sram_valid, 1);
    check("ifu_t1_addr", sram_addr, 32'h8000_0000);
    check("ifu_t1_wen", sram_wen, 0);
    check("ifu_t1_ready", ifu_ready, 0);
    @(posedge clk); #1;
    sram_ready = 1'b1; sram_rdata = 32'h0000_0413;
    #1;
    check("ifu_t2_ready", ifu_ready, 1);
    check("ifu_t2_rdata", ifu_rdata, 32'h0000_0413);
    check("ifu_t2_lsu_ready", lsu_ready, 0);
    check("ifu_t2_lsu_rdata", lsu_rdata, 0);
    check("ifu_t2_err", err, 0);
    ifu_valid = 1'b0;
    @(posedge clk); #1;
    sram_ready = 1'b0;
    #1;
    check("ifu_t3_idle", sram_valid, 0);
    check("ifu_t3_ready", ifu_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000001 want 0x00000000");
    $fatal(1, "bench time limit reached");
  end

endmodule : tb_ysyx_24090012_mem_arb
`default_nettype wire

// File: doc/ysyx_24090012_mem_arb.md
# ysyx_24090012_mem_arb

Two-master, one-slave arbiter that shares the single SRAM port between the IFU (read-only) and the LSU (read/write). Sits between both fetch/load-store units and the SRAM, using the same valid/ready/addr/rdata/wdata/wmask/wen handshake on every side. It latches the granted request, drives the SRAM from that copy, and routes the response back to the owner only. A response watchdog keeps a hung slave from deadlocking the core.

## Interface
- TIMEOUT, default 255: SRAM response cycles allowed before a forced error response; 8-bit counter.
- ERR_RDATA, default 32'hDEAD_BEEF: rdata returned on timeout.
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- ifu_valid / ifu_addr  in  1 / 32  IFU read request
- ifu_ready / ifu_rdata  out  1 / 32  IFU response
- lsu_valid / lsu_addr / lsu_wdata / lsu_wmask / lsu_wen  in  1/32/32/4/1  LSU request
- lsu_ready / lsu_rdata  out  1 / 32  LSU response
- sram_valid / sram_addr / sram_wdata / sram_wmask / sram_wen  out  1/32/32/4/1  SRAM request
- sram_ready / sram_rdata  in  1 / 32  SRAM response
- err  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, GNT_IFU, GNT_LSU.
- IDLE: no sram_valid. If any master valid, pick winner, latch its addr/wdata/wmask/wen (IFU: wdata=0, wmask=0, wen=0), clear watchdog, go to GNT_x.
- GNT_x: sram_valid=1, sram_* from latched copy. Master must hold valid until its ready; arbiter ignores master-side changes while granted.
- sram_ready in GNT_x: x_ready=1 and x_rdata=sram_rdata same cycle (combinational); next state IDLE. Non-granted master's ready is 0; its rdata is 0.
- Watchdog: increments each GNT_x cycle without sram_ready; on reaching TIMEOUT: x_ready=1, x_rdata=ERR_RDATA, err=1, sram_valid=0 that cycle, next IDLE. sram_ready in the same cycle wins over timeout (normal response, no err).
- Priority (macro off): LSU over IFU on simultaneous request.
- A master dropping valid while granted does not abort; the transaction completes and ready is still pulsed.

## Timing
- Reset (async assert): state IDLE, latches 0, watchdog 0, RR pointer = LSU-last; all outputs 0 while rst_n low and in cycle after release.
- Request seen in IDLE at cycle t -> sram_valid from t+1. SRAM ready at t+k -> master ready at t+k. Earliest next grant decision at t+k+1 (IDLE), sram_valid at t+k+2.
- Minimum: one transaction per 3 cycles with a 1-cycle SRAM.
- Reset asserted mid-transaction: grant dropped immediately, no ready pulse issued; the SRAM may see valid deassert without completion.
- Watchdog width 8 bits; TIMEOUT ≥ 1; no wrap (stops at expiry).

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin; on simultaneous request grant the master not served last; pointer updated on every grant; after reset IFU wins first tie.
- Undefined: fixed LSU > IFU priority; pointer logic absent.

## Structure
- Shared package: state enum (IDLE/GNT_IFU/GNT_LSU), master-id constants, default ERR_RDATA.
- One sub-module natural: ysyx_24090012_arb_wdog (counter, clear, enable, expiry flag).
- Request latch and mux stay in top.

## Test plan
- IFU alone, addr 0x8000_0000, SRAM ready after 1 cycle -> sram_valid at t+1, ifu_ready with rdata 0x0000_0413 at t+2, lsu_ready stays 0, sram_wen=0.
- Both valid same cycle (macro off), LSU write 0x8000_0100 data 0x1234_5678 mask 4'hF -> LSU granted first; IFU granted in the IDLE cycle after lsu_ready.
- Macro on, both valid continuously for 4 transactions -> grant order IFU, LSU, IFU, LSU.
- SRAM never ready, TIMEOUT=4 -> after 4 GNT cycles ifu_ready=1, ifu_rdata=0xDEAD_BEEF, err pulses 1 cycle, state IDLE.
- sram_ready and timeout in same cycle -> normal rdata, err=0.
- rst_n pulled low during GNT_LSU -> outputs 0 immediately, no lsu_ready; after release IFU request served normally.
